// File: rtl/flash_read_master_if.sv
// flash_read_master_if: request side and Avalon-MM read side of the flash read master
interface flash_read_master_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              timeout_err;
  modport master (
    input  req, req_addr, flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
    output flash_mem_read, flash_mem_address, rd_data, rd_valid, busy, timeout_err
  );
  modport slave (
    output req, req_addr, flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
    input  flash_mem_read, flash_mem_address, rd_data, rd_valid, busy, timeout_err
  );
endinterface

// File: rtl/flash_read_master.sv
// flash_read_master: single-word Avalon-MM read master with a data watchdog
module flash_read_master #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset_n,
  flash_read_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  state_t     state;
  logic [7:0] wd;
  // One read in flight: issue, hold through waitrequest, then wait for data or the watchdog
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state                 <= IDLE;
      wd                    <= '0;
      bus.flash_mem_read    <= 1'b0;
      bus.flash_mem_address <= '0;
      bus.rd_data           <= '0;
      bus.rd_valid          <= 1'b0;
      bus.busy              <= 1'b0;
      bus.timeout_err       <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          state                 <= ISSUE;
          bus.flash_mem_address <= bus.req_addr;
          bus.flash_mem_read    <= 1'b1;
          bus.busy              <= 1'b1;
          bus.timeout_err       <= 1'b0;
        end
        ISSUE: if (!bus.flash_mem_waitrequest) begin
          state              <= WAIT_DATA;
          bus.flash_mem_read <= 1'b0;
          wd                 <= '0;
        end
        WAIT_DATA: if (bus.flash_mem_readdatavalid) begin
          state        <= IDLE;
          bus.rd_data  <= bus.flash_mem_readdata;
          bus.rd_valid <= 1'b1;
          bus.busy     <= 1'b0;
        end else if (wd == WD_LAST) begin
          state           <= IDLE;
          bus.timeout_err <= 1'b1;
          bus.busy        <= 1'b0;
        end else begin
          wd <= wd + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_flash_read_master.sv
// tb_flash_read_master: scoreboard bench driving a hand-scripted Avalon slave
module tb_flash_read_master;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int passed = 0;
  int total = 0;
  logic [DW-1:0] exp_q[$];
  flash_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  flash_read_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: every rd_valid pulse must match the next expected word
  always @(negedge clk)
    if (reset_n && bus.rd_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
      else chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stalls,
                         input int k, input string tag);
    bus.req = 1'b1;
    bus.req_addr = a;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i <= stalls; i++) begin
      bus.flash_mem_waitrequest = (i < stalls);
      chk({tag, "_read_high"}, 32'(bus.flash_mem_read), 32'd1);
      chk({tag, "_addr"}, 32'(bus.flash_mem_address), 32'(a));
      tick();
    end
    bus.flash_mem_waitrequest = 1'b0;
    chk({tag, "_read_dropped"}, 32'(bus.flash_mem_read), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    repeat (k - 1) tick();
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = d;
    exp_q.push_back(d);
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata = '0;
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    bus.req = 1'b0;
    bus.req_addr = '0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata = '0;
    repeat (2) tick();
    chk("rst_read", 32'(bus.flash_mem_read), 32'd0);
    chk("rst_addr", 32'(bus.flash_mem_address), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    // zero-wait read, data two cycles after accept
    do_read(23'h000010, 32'hA1B2C3D4, 0, 2, "t1");
    tick();
    chk("t1_held", bus.rd_data, 32'hA1B2C3D4);
    // three waitrequest stalls
    do_read(23'h001234, 32'h5EED0002, 3, 1, "t2");
    tick();
    // watchdog expiry
    bus.req = 1'b1;
    bus.req_addr = 23'h2AAAAA;
    tick();
    bus.req = 1'b0;
    tick();
    repeat (7) tick();
    chk("t3_busy_before_expiry", 32'(bus.busy), 32'd1);
    chk("t3_err_before_expiry", 32'(bus.timeout_err), 32'd0);
    tick();
    chk("t3_busy_after_expiry", 32'(bus.busy), 32'd0);
    chk("t3_timeout_err", 32'(bus.timeout_err), 32'd1);
    chk("t3_rd_data_kept", bus.rd_data, 32'h5EED0002);
    do_read(23'h000100, 32'h00000033, 0, 1, "t3b");
    chk("t3_err_cleared", 32'(bus.timeout_err), 32'd0);
    tick();
    // data on the same edge the watchdog expires: data wins
    bus.req = 1'b1;
    bus.req_addr = 23'h000200;
    tick();
    bus.req = 1'b0;
    tick();
    repeat (7) tick();
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'hCAFE0008;
    exp_q.push_back(32'hCAFE0008);
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    chk("t3c_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("t3c_no_err", 32'(bus.timeout_err), 32'd0);
    tick();
    // stray data in IDLE and ISSUE, req pulses while busy
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'hDEADDEAD;
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    tick();
    chk("t4_idle_stray", bus.rd_data, 32'hCAFE0008);
    bus.req = 1'b1;
    bus.req_addr = 23'h000111;
    tick();
    bus.req_addr = 23'h000222;
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'hBADBAD00;
    bus.flash_mem_waitrequest = 1'b1;
    chk("t4_issue_addr", 32'(bus.flash_mem_address), 32'h111);
    tick();
    bus.req = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_waitrequest = 1'b0;
    chk("t4_issue_stray", bus.rd_data, 32'hCAFE0008);
    chk("t4_addr_held", 32'(bus.flash_mem_address), 32'h111);
    tick();
    bus.req = 1'b1;
    bus.req_addr = 23'h000333;
    tick();
    bus.req = 1'b0;
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'h44444444;
    exp_q.push_back(32'h44444444);
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    chk("t4_rd_valid", 32'(bus.rd_valid), 32'd1);
    tick();
    chk("t4_no_extra_read", 32'(bus.flash_mem_read), 32'd0);
    chk("t4_no_extra_busy", 32'(bus.busy), 32'd0);
    // back-to-back with req held high
    bus.req = 1'b1;
    bus.req_addr = 23'h7FFFFF;
    tick();
    chk("t5_addr_a", 32'(bus.flash_mem_address), 32'h7FFFFF);
    bus.req_addr = 23'h000000;
    tick();
    chk("t5_read_dropped", 32'(bus.flash_mem_read), 32'd0);
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'h7F7F7F7F;
    exp_q.push_back(32'h7F7F7F7F);
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    chk("t5_rd_valid_a", 32'(bus.rd_valid), 32'd1);
    tick();
    bus.req = 1'b0;
    chk("t5_read_b", 32'(bus.flash_mem_read), 32'd1);
    chk("t5_addr_b", 32'(bus.flash_mem_address), 32'h0);
    tick();
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'h00000001;
    exp_q.push_back(32'h00000001);
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    chk("t5_rd_valid_b", 32'(bus.rd_valid), 32'd1);
    tick();
    chk("t5_idle", 32'(bus.busy), 32'd0);
    // async reset in WAIT_DATA, then in ISSUE
    bus.req = 1'b1;
    bus.req_addr = 23'h000055;
    tick();
    bus.req = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_read", 32'(bus.flash_mem_read), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("t6_rd_data", bus.rd_data, 32'd0);
    chk("t6_addr", 32'(bus.flash_mem_address), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    bus.req = 1'b1;
    bus.req_addr = 23'h000066;
    tick();
    bus.req = 1'b0;
    bus.flash_mem_waitrequest = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_issue_read", 32'(bus.flash_mem_read), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    bus.flash_mem_waitrequest = 1'b0;
    tick();
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'h99999999;
    tick();
    bus.flash_mem_readdatavalid = 1'b0;
    tick();
    chk("t6_late_valid", bus.rd_data, 32'd0);
    chk("t6_late_busy", 32'(bus.busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
